div8x4_seq: RTL and testbench



---
 rtl/div8x4_seq.sv | 199 +++++++++++++++++++
 tb/tb_div8x4_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/div8x4_seq.sv
// Sequential signed divider: restoring shift/subtract on magnitudes, one quotient bit per clock, then sign fix-up.
// Optional build macro DIV_EARLY_TERM_EN skips the iterations when |InA| < |InB|.
module div8x4_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DIVIDEND_W-1:0] InA,
  input  logic [DIVISOR_W-1:0]  InB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DIVIDEND_W-1:0] Quotient,
  output logic [DIVISOR_W-1:0]  Remainder,
  output logic                  DivByZero,
  output logic                  Overflow
);
  localparam int DW = DIVIDEND_W;
  localparam int VW = DIVISOR_W;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DIVIDE, S_FIXUP} state_t;

  state_t        r_state, w_state_next;
  logic [DW-1:0] r_a, w_a_next;
  logic [VW-1:0] r_b, w_b_next;
  logic [DW-1:0] r_quo_mag, w_quo_mag_next;
  logic [VW-1:0] r_rem_mag, w_rem_mag_next;
  logic [VW-1:0] r_mag_b, w_mag_b_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_qsign, w_qsign_next;
  logic          r_rsign, w_rsign_next;
  logic          r_dbz_pend, w_dbz_pend_next;
  logic          r_ovf_pend, w_ovf_pend_next;
  logic          r_busy, w_busy_next;
  logic          r_done, w_done_next;
  logic [DW-1:0] r_quotient, w_quotient_next;
  logic [VW-1:0] r_remainder, w_remainder_next;
  logic          r_divbyzero, w_divbyzero_next;
  logic          r_overflow, w_overflow_next;

  logic [DW-1:0] w_mag_a;
  logic [VW-1:0] w_mag_b;
  logic          w_is_dbz;
  logic          w_is_ovf;
  logic [VW:0]   w_shift_rem;
  logic          w_trial_ge;
  logic [VW-1:0] w_trial_diff;

  // |most-negative| still fits because the magnitude is treated as unsigned
  assign w_mag_a  = r_a[DW-1] ? (~r_a + DW'(1)) : r_a;
  assign w_mag_b  = r_b[VW-1] ? (~r_b + VW'(1)) : r_b;
  assign w_is_dbz = (r_b == '0);
  assign w_is_ovf = (r_a == MOST_NEG) && (r_b == '1);

  // The remainder is always below |divisor|, so the difference fits VW bits
  assign w_shift_rem  = {r_rem_mag, r_quo_mag[DW-1]};
  assign w_trial_ge   = (w_shift_rem >= {1'b0, r_mag_b});
  assign w_trial_diff = VW'(w_shift_rem - {1'b0, r_mag_b});

  always_comb begin
    w_state_next     = r_state;
    w_a_next         = r_a;
    w_b_next         = r_b;
    w_quo_mag_next   = r_quo_mag;
    w_rem_mag_next   = r_rem_mag;
    w_mag_b_next     = r_mag_b;
    w_cnt_next       = r_cnt;
    w_qsign_next     = r_qsign;
    w_rsign_next     = r_rsign;
    w_dbz_pend_next  = r_dbz_pend;
    w_ovf_pend_next  = r_ovf_pend;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_quotient_next  = r_quotient;
    w_remainder_next = r_remainder;
    w_divbyzero_next = r_divbyzero;
    w_overflow_next  = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_a_next     = InA;
          w_b_next     = InB;
          w_busy_next  = 1'b1;
          w_state_next = S_SETUP;
        end
      end

      S_SETUP: begin
        w_qsign_next    = r_a[DW-1] ^ r_b[VW-1];
        w_rsign_next    = r_a[DW-1];
        w_dbz_pend_next = w_is_dbz;
        w_ovf_pend_next = w_is_ovf;
        w_mag_b_next    = w_mag_b;
        w_quo_mag_next  = w_mag_a;
        w_rem_mag_next  = '0;
        w_cnt_next      = CW'(DW - 1);
        if (w_is_dbz || w_is_ovf) begin
          w_state_next = S_FIXUP;
`ifdef DIV_EARLY_TERM_EN
        end else if (w_mag_a < DW'(w_mag_b)) begin
          w_quo_mag_next = '0;
          w_rem_mag_next = VW'(w_mag_a);
          w_state_next   = S_FIXUP;
`endif
        end else begin
          w_state_next = S_DIVIDE;
        end
      end

      S_DIVIDE: begin
        if (w_trial_ge) begin
          w_rem_mag_next = w_trial_diff;
          w_quo_mag_next = {r_quo_mag[DW-2:0], 1'b1};
        end else begin
          w_rem_mag_next = w_shift_rem[VW-1:0];
          w_quo_mag_next = {r_quo_mag[DW-2:0], 1'b0};
        end
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_state_next = S_FIXUP;
        end
      end

      S_FIXUP: begin
        w_done_next      = 1'b1;
        w_busy_next      = 1'b0;
        w_state_next     = S_IDLE;
        w_divbyzero_next = r_dbz_pend;
        w_overflow_next  = r_ovf_pend;
        if (r_dbz_pend) begin
          w_quotient_next  = '1;
          w_remainder_next = '0;
        end else if (r_ovf_pend) begin
          w_quotient_next  = MOST_NEG;
          w_remainder_next = '0;
        end else begin
          w_quotient_next  = r_qsign ? (~r_quo_mag + DW'(1)) : r_quo_mag;
          w_remainder_next = r_rsign ? (~r_rem_mag + VW'(1)) : r_rem_mag;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_quo_mag   <= '0;
      r_rem_mag   <= '0;
      r_mag_b     <= '0;
      r_cnt       <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_dbz_pend  <= 1'b0;
      r_ovf_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divbyzero <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_a         <= w_a_next;
      r_b         <= w_b_next;
      r_quo_mag   <= w_quo_mag_next;
      r_rem_mag   <= w_rem_mag_next;
      r_mag_b     <= w_mag_b_next;
      r_cnt       <= w_cnt_next;
      r_qsign     <= w_qsign_next;
      r_rsign     <= w_rsign_next;
      r_dbz_pend  <= w_dbz_pend_next;
      r_ovf_pend  <= w_ovf_pend_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_quotient  <= w_quotient_next;
      r_remainder <= w_remainder_next;
      r_divbyzero <= w_divbyzero_next;
      r_overflow  <= w_overflow_next;
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Quotient  = r_quotient;
  assign Remainder = r_remainder;
  assign DivByZero = r_divbyzero;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_div8x4_seq.sv
// Directed bench for div8x4_seq: latency, signed results, special cases, handshake corners, mid-run reset.
module tb_div8x4_seq;
  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] InA;
  logic [3:0] InB;
  logic       Busy;
  logic       Done;
  logic [7:0] Quotient;
  logic [3:0] Remainder;
  logic       DivByZero;
  logic       Overflow;

  int total = 0;
  int bad   = 0;

  div8x4_seq #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InA(InA), .InB(InB),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
    .DivByZero(DivByZero), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drives one operation from the current cycle and waits (bounded) for Done.
  // lat counts edges after the Start edge; 40 means the wait expired.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       output int lat, output logic busy_ok);
    Start = 1'b1; InA = a; InB = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    busy_ok = (Busy === 1'b1);
    lat = 0;
    while (lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (Done === 1'b1) break;
      if (Busy !== 1'b1) busy_ok = 1'b0;
    end
    $display("op a=%02h b=%01h -> q=%02h r=%01h dbz=%0b ovf=%0b lat=%0d",
             a, b, Quotient, Remainder, DivByZero, Overflow, lat);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", Done); end
    total++; if (Quotient !== 8'h00 || Remainder !== 4'h0) begin bad++;
      $display("FAIL reset_result got=%02h/%01h want=00/0", Quotient, Remainder); end
    total++; if (DivByZero !== 1'b0 || Overflow !== 1'b0) begin bad++;
      $display("FAIL reset_flags got=%0b%0b want=00", DivByZero, Overflow); end
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic bok;
    do_op(8'd100, 4'd7, lat, bok);
    total++; if (lat !== 10) begin bad++; $display("FAIL basic_latency got=%0d want=10", lat); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy_window got=%0b want=1", bok); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%0b want=0", Busy); end
    total++; if (Quotient !== 8'h0E || Remainder !== 4'h2) begin bad++;
      $display("FAIL basic_result got=%02h/%01h want=0E/2", Quotient, Remainder); end
    total++; if (DivByZero !== 1'b0 || Overflow !== 1'b0) begin bad++;
      $display("FAIL basic_flags got=%0b%0b want=00", DivByZero, Overflow); end
    @(posedge Clk); #1;
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL done_width got=%0b want=0", Done); end
    total++; if (Quotient !== 8'h0E || Remainder !== 4'h2) begin bad++;
      $display("FAIL result_hold got=%02h/%01h want=0E/2", Quotient, Remainder); end
  endtask

  task automatic test_signs();
    int lat; logic bok;
    do_op(8'h9C, 4'd7, lat, bok);
    total++; if (Quotient !== 8'hF2 || Remainder !== 4'hE || lat !== 10) begin bad++;
      $display("FAIL neg_dividend got=%02h/%01h lat=%0d want=F2/E lat=10", Quotient, Remainder, lat); end
    do_op(8'd100, 4'h8, lat, bok);
    total++; if (Quotient !== 8'hF4 || Remainder !== 4'h4 || lat !== 10) begin bad++;
      $display("FAIL neg_divisor got=%02h/%01h lat=%0d want=F4/4 lat=10", Quotient, Remainder, lat); end
  endtask

  task automatic test_special();
    int lat; logic bok;
    do_op(8'h80, 4'hF, lat, bok);
    total++; if (lat !== 2) begin bad++; $display("FAIL ovf_latency got=%0d want=2", lat); end
    total++; if (Quotient !== 8'h80 || Remainder !== 4'h0 || Overflow !== 1'b1 || DivByZero !== 1'b0) begin bad++;
      $display("FAIL ovf_result got=%02h/%01h ovf=%0b dbz=%0b want=80/0 ovf=1 dbz=0",
               Quotient, Remainder, Overflow, DivByZero); end
    do_op(8'd5, 4'h0, lat, bok);
    total++; if (lat !== 2) begin bad++; $display("FAIL dbz_latency got=%0d want=2", lat); end
    total++; if (Quotient !== 8'hFF || Remainder !== 4'h0 || DivByZero !== 1'b1 || Overflow !== 1'b0) begin bad++;
      $display("FAIL dbz_result got=%02h/%01h dbz=%0b ovf=%0b want=FF/0 dbz=1 ovf=0",
               Quotient, Remainder, DivByZero, Overflow); end
    @(posedge Clk); #1;
  endtask

  task automatic test_busy_ignore_and_back_to_back();
    int lat; logic bok;
    Start = 1'b1; InA = 8'd100; InB = 4'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (Done === 1'b1) break;
      // Stray requests land on edges 3 and 5 with different operands
      if (lat == 2 || lat == 4) begin Start = 1'b1; InA = 8'hFB; InB = 4'd3; end
      else Start = 1'b0;
    end
    Start = 1'b0;
    $display("op a=64 b=7 (stray starts) -> q=%02h r=%01h lat=%0d", Quotient, Remainder, lat);
    total++; if (Quotient !== 8'h0E || Remainder !== 4'h2 || lat !== 10) begin bad++;
      $display("FAIL busy_ignore got=%02h/%01h lat=%0d want=0E/2 lat=10", Quotient, Remainder, lat); end
    // Start issued in the Done cycle
    do_op(8'd127, 4'd3, lat, bok);
    total++; if (Quotient !== 8'h2A || Remainder !== 4'h1 || lat !== 10) begin bad++;
      $display("FAIL back_to_back got=%02h/%01h lat=%0d want=2A/1 lat=10", Quotient, Remainder, lat); end
    total++; if (DivByZero !== 1'b0 || Overflow !== 1'b0) begin bad++;
      $display("FAIL flags_cleared got=%0b%0b want=00", DivByZero, Overflow); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic bok; int done_seen;
    Start = 1'b1; InA = 8'h9C; InB = 4'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    $display("reset at edge 5 -> busy=%0b q=%02h r=%01h", Busy, Quotient, Remainder);
    total++; if (Busy !== 1'b0 || Done !== 1'b0) begin bad++;
      $display("FAIL midreset_ctrl got busy=%0b done=%0b want=0/0", Busy, Done); end
    total++; if (Quotient !== 8'h00 || Remainder !== 4'h0 || DivByZero !== 1'b0 || Overflow !== 1'b0) begin bad++;
      $display("FAIL midreset_outputs got=%02h/%01h %0b%0b want=00/0 00",
               Quotient, Remainder, DivByZero, Overflow); end
    done_seen = 0;
    repeat (12) begin @(posedge Clk); #1; if (Done === 1'b1) done_seen++; end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", done_seen); end
    do_op(8'd100, 4'd7, lat, bok);
    total++; if (Quotient !== 8'h0E || Remainder !== 4'h2 || lat !== 10) begin bad++;
      $display("FAIL after_reset got=%02h/%01h lat=%0d want=0E/2 lat=10", Quotient, Remainder, lat); end
    @(posedge Clk); #1;
  endtask

  task automatic test_early_term();
    int lat; logic bok; int exp_lat;
`ifdef DIV_EARLY_TERM_EN
    exp_lat = 2;
`else
    exp_lat = 10;
`endif
    do_op(8'd3, 4'h9, lat, bok);
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL small_latency got=%0d want=%0d", lat, exp_lat); end
    total++; if (Quotient !== 8'h00 || Remainder !== 4'h3) begin bad++;
      $display("FAIL small_result got=%02h/%01h want=00/3", Quotient, Remainder); end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; InA = '0; InB = '0;
    test_reset();
    test_basic();
    test_signs();
    test_special();
    test_busy_ignore_and_back_to_back();
    test_reset_mid();
    test_early_term();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
